// File: rtl/d_imm_gen.sv
// d_imm_gen: decode-stage immediate extender behind a 2-entry (OUT + SKID) valid/ready stage.
// Optional macro D_IMM_GEN_BRANCH_EN enables branch-offset mode 3 (s << 2) for opcodes 000100/000101.
module d_imm_gen #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [IMM_W-1:0]  i_data_immD,
  input  logic [5:0]        i_data_opcode,
  input  logic [5:0]        i_data_funct,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data_immD,
  output logic [1:0]        o_data_mode
);

  localparam int FILL_W = DATA_W - IMM_W;

  generate
    if (DATA_W < IMM_W + 2) begin : g_bad_width
      $error("d_imm_gen: DATA_W must be at least IMM_W + 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              r_rdy_en;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_mode;
  logic [DATA_W-1:0] r_skid_data;
  logic [1:0]        r_skid_mode;

  logic [1:0]        w_mode;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_upper;
  logic [DATA_W-1:0] w_ext;
  logic              w_accept;
  logic              w_load_out_in;
  logic              w_load_out_skid;
  logic              w_load_skid;

  // Mode decode from opcode/funct
  always_comb begin
    w_mode = 2'd1;
    case (i_data_opcode)
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b100011, 6'b101011: w_mode = 2'd0;
      6'b001100, 6'b001101, 6'b001110: w_mode = 2'd1;
      6'b001111: w_mode = 2'd2;
`ifdef D_IMM_GEN_BRANCH_EN
      6'b000100, 6'b000101: w_mode = 2'd3;
`else
      6'b000100, 6'b000101: w_mode = 2'd0;
`endif
      6'b000000: begin
        if (i_data_funct == 6'b100000 || i_data_funct == 6'b100010) begin
          w_mode = 2'd0;
        end else begin
          w_mode = 2'd1;
        end
      end
      default: w_mode = 2'd1;
    endcase
  end

  assign w_sext  = {{FILL_W{i_data_immD[IMM_W-1]}}, i_data_immD};
  assign w_zext  = {{FILL_W{1'b0}}, i_data_immD};
  assign w_upper = {i_data_immD, {FILL_W{1'b0}}};

`ifdef D_IMM_GEN_BRANCH_EN
  logic [DATA_W-1:0] w_branch;
  // The two sign bits shifted out of the top are intentionally lost.
  assign w_branch = {w_sext[DATA_W-3:0], 2'b00};
`endif

  always_comb begin
    w_ext = w_zext;
    case (w_mode)
      2'd0:    w_ext = w_sext;
      2'd2:    w_ext = w_upper;
`ifdef D_IMM_GEN_BRANCH_EN
      2'd3:    w_ext = w_branch;
`endif
      default: w_ext = w_zext;
    endcase
  end

  // r_rdy_en keeps o_ready low during reset and lifts it at the first edge after release.
  assign o_ready  = r_rdy_en && (r_state != S_FULL);
  assign o_valid  = (r_state != S_EMPTY);
  assign w_accept = i_valid && o_ready;

  always_comb begin
    w_state_next    = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (i_flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_load_out_in = 1'b1;
            w_state_next  = S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && i_ready) begin
            w_load_out_in = 1'b1;
          end else if (w_accept) begin
            w_load_skid  = 1'b1;
            w_state_next = S_FULL;
          end else if (i_ready) begin
            w_state_next = S_EMPTY;
          end
        end
        S_FULL: begin
          if (i_ready) begin
            w_load_out_skid = 1'b1;
            w_state_next    = S_ONE;
          end
        end
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_EMPTY;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_data  <= '0;
      r_out_mode  <= 2'd0;
      r_skid_data <= '0;
      r_skid_mode <= 2'd0;
    end else begin
      if (w_load_out_in) begin
        r_out_data <= w_ext;
        r_out_mode <= w_mode;
      end else if (w_load_out_skid) begin
        r_out_data <= r_skid_data;
        r_out_mode <= r_skid_mode;
      end
      if (w_load_skid) begin
        r_skid_data <= w_ext;
        r_skid_mode <= w_mode;
      end
    end
  end

  assign o_data_immD = r_out_data;
  assign o_data_mode = r_out_mode;

endmodule

// File: tb/tb_d_imm_gen.sv
// Scoreboard bench for d_imm_gen: driver pushes expected results, negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_d_imm_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_data_immD = '0;
  logic [5:0]  i_data_opcode = '0;
  logic [5:0]  i_data_funct = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_data_immD;
  logic [1:0]  o_data_mode;

  always #5 clk = ~clk;

  d_imm_gen #(.IMM_W(16), .DATA_W(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_data_immD   (i_data_immD),
    .i_data_opcode (i_data_opcode),
    .i_data_funct  (i_data_funct),
    .i_flush       (i_flush),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data_immD   (o_data_immD),
    .o_data_mode   (o_data_mode)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

`ifdef D_IMM_GEN_BRANCH_EN
  localparam logic [31:0] BEQ_DATA = 32'hFFFF_FFFC;
  localparam logic [1:0]  BEQ_MODE = 2'd3;
  localparam logic [31:0] BNE_DATA = 32'h0001_0004;
  localparam logic [1:0]  BNE_MODE = 2'd3;
`else
  localparam logic [31:0] BEQ_DATA = 32'hFFFF_FFFF;
  localparam logic [1:0]  BEQ_MODE = 2'd0;
  localparam logic [31:0] BNE_DATA = 32'h0000_4001;
  localparam logic [1:0]  BNE_MODE = 2'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic send(input string name, input logic [5:0] op, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [31:0] exp_data,
                      input logic [1:0] exp_mode);
    int waited;
    waited        = 0;
    i_valid       = 1'b1;
    i_data_opcode = op;
    i_data_funct  = fn;
    i_data_immD   = imm;
    @(negedge clk);
    while (!o_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!o_ready) begin
      chk({name, "_accept_timeout"}, 32'(o_ready), 32'd1);
    end else begin
      sb_q.push_back('{data: exp_data, mode: exp_mode});
      $display("send %s: op=%b funct=%b imm=%h expect %h mode %0d", name, op, fn, imm,
               exp_data, exp_mode);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Monitor: every valid output must match the scoreboard head; pop on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && o_valid) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got data %h mode %0d, required no output",
                   o_data_immD, o_data_mode);
        end else begin
          chk("out_data", o_data_immD, sb_q[0].data);
          chk("out_mode", 32'(o_data_mode), 32'(sb_q[0].mode));
          if (i_ready) begin
            $display("recv: data %h mode %0d", o_data_immD, o_data_mode);
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_data",  o_data_immD,  32'd0);
    chk("rst_mode",  32'(o_data_mode), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(o_ready), 32'd1);

    // Directed decode vectors, back to back with i_ready high
    i_ready = 1'b1;
    send("addi_neg", 6'b001000, 6'b000000, 16'hFFFE, 32'hFFFF_FFFE, 2'd0);
    chk("latency_valid", 32'(o_valid), 32'd1);
    chk("latency_data",  o_data_immD,  32'hFFFF_FFFE);
    send("ori",      6'b001101, 6'b000000, 16'h8001, 32'h0000_8001, 2'd1);
    send("lui",      6'b001111, 6'b000000, 16'h1234, 32'h1234_0000, 2'd2);
    send("r_and",    6'b000000, 6'b100100, 16'h8000, 32'h0000_8000, 2'd1);
    send("r_add",    6'b000000, 6'b100000, 16'h8000, 32'hFFFF_8000, 2'd0);
    send("lw",       6'b100011, 6'b000000, 16'h7FFF, 32'h0000_7FFF, 2'd0);
    send("beq",      6'b000100, 6'b000000, 16'hFFFF, BEQ_DATA,      BEQ_MODE);
    send("bne",      6'b000101, 6'b000000, 16'h4001, BNE_DATA,      BNE_MODE);
    send("other",    6'b111111, 6'b000000, 16'h8000, 32'h0000_8000, 2'd1);
    @(posedge clk);
    #1;

    // Back-pressure: A held, B goes to skid, C waits until drain
    send("bp_a", 6'b001001, 6'b000000, 16'h0011, 32'h0000_0011, 2'd0);
    i_ready = 1'b0;
    send("bp_b", 6'b001110, 6'b000000, 16'hF022, 32'h0000_F022, 2'd1);
    chk("bp_ready_low", 32'(o_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_ready_still_low", 32'(o_ready), 32'd0);
    chk("bp_held_data", o_data_immD, 32'h0000_0011);
    i_ready = 1'b1;
    send("bp_c", 6'b101011, 6'b000000, 16'h8033, 32'hFFFF_8033, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", 32'(o_valid), 32'd0);

    // Flush while FULL with a new entry offered
    send("fl_d", 6'b001010, 6'b000000, 16'h0044, 32'h0000_0044, 2'd0);
    i_ready = 1'b0;
    send("fl_e", 6'b001100, 6'b000000, 16'h0055, 32'h0000_0055, 2'd1);
    i_valid       = 1'b1;
    i_data_opcode = 6'b001111;
    i_data_immD   = 16'hDEAD;
    i_flush       = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_ready", 32'(o_ready), 32'd1);
    sb_q.delete();
    i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_no_output", 32'(o_valid), 32'd0);

    // Asynchronous reset mid-cycle while FULL
    send("ar_g", 6'b001101, 6'b000000, 16'h00AA, 32'h0000_00AA, 2'd1);
    i_ready = 1'b0;
    send("ar_h", 6'b001111, 6'b000000, 16'h5555, 32'h5555_0000, 2'd2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_data",  o_data_immD,  32'd0);
    chk("arst_mode",  32'(o_data_mode), 32'd0);
    chk("arst_ready", 32'(o_ready), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ready_back", 32'(o_ready), 32'd1);
    send("post_rst", 6'b001011, 6'b000000, 16'h9000, 32'hFFFF_9000, 2'd0);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/d_imm_gen.md
# d_imm_gen

Parametrised, handshaked immediate generator for the decode stage. Accepts a raw instruction immediate with its opcode/funct and produces an extended operand (sign, zero, upper, or branch offset) for the execute stage. It replaces the single-register extender with a 2-entry skid-buffered valid/ready pipeline stage that supports flush and back-pressure.

## Interface
- `IMM_W`, 16: raw immediate width.
- `DATA_W`, 32: extended output width. Must satisfy `DATA_W >= IMM_W + 2`.
- `i_clk`  in  1: clock, rising edge.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_valid`  in  1: upstream has an instruction.
- `o_ready`  out  1: stage can accept. A transfer occurs when `i_valid && o_ready`.
- `i_data_immD`  in  IMM_W: raw immediate.
- `i_data_opcode`  in  6: instruction opcode.
- `i_data_funct`  in  6: R-type funct field.
- `i_flush`  in  1: discard all held and incoming entries.
- `o_valid`  out  1: output entry valid.
- `i_ready`  in  1: downstream accepts. A transfer occurs when `o_valid && i_ready`.
- `o_data_immD`  out  DATA_W: extended immediate.
- `o_data_mode`  out  2: extension mode applied (0 sign, 1 zero, 2 upper, 3 branch).

## Operation
Mode decode, where s is the sign-extended immediate:
- Opcodes 001000, 001001, 001010, 001011, 100011, 101011 -> mode 0: `{sign fill, imm}`.
- Opcodes 001100, 001101, 001110 -> mode 1: `{zeros, imm}`.
- Opcode 001111 -> mode 2: imm placed in bits `[DATA_W-1 : DATA_W-IMM_W]`, zeros below.
- Opcodes 000100, 000101 -> mode 3: `s << 2`. The top 2 bits of s are dropped and bits [1:0] are 0.
- Opcode 000000 with funct 100000 or 100010 -> mode 0. Any other funct -> mode 1.
- Any other opcode -> mode 1.

Extension is computed combinationally at the input and captured into the output register or the skid register.

Storage is an output register (OUT) plus one skid register (SKID). The state machine has three states:
- EMPTY: `o_valid=0`, `o_ready=1`.
  - On accept -> ONE.
- ONE: `o_valid=1`, `o_ready=1`.
  - Accept with `i_ready` -> stay in ONE; OUT is loaded with the new entry.
  - Accept without `i_ready` -> FULL; the new entry goes to SKID.
  - No accept with `i_ready` -> EMPTY.
  - Otherwise hold.
- FULL: `o_valid=1`, `o_ready=0`.
  - On `i_ready` -> ONE; SKID moves to OUT.
  - Otherwise hold.

Flush:
- `i_flush=1` at an edge forces EMPTY, regardless of state.
- Any entry offered in that cycle is dropped.
- `o_data_immD` and `o_data_mode` keep their last values and are don't-care while `o_valid=0`.
- Flush has priority over accept and drain.

Handshake rules:
- `o_ready` is a function of state only, with no combinational path from `i_ready`.
- Held output data must not change while `o_valid && !i_ready`.

## Timing
- Reset values: state EMPTY, `o_valid=0`, `o_data_immD=0`, `o_data_mode=0`.
- `o_ready` is 0 while `i_rst` is asserted and 1 at the first edge after release.
- Latency is 1 cycle: an entry accepted at edge N is on the outputs after edge N.
- Throughput is 1 entry per cycle while `i_ready` stays high.
- After one back-pressure cycle, `o_ready` drops for exactly the cycles spent in FULL.
- Asserting reset mid-operation clears everything immediately (asynchronous). No partial entry survives.
- Simultaneous accept and drain in ONE: the output is updated with no bubble.
- Simultaneous flush and reset: reset dominates. The result is the same EMPTY state.

## Configuration
- `D_IMM_GEN_BRANCH_EN` defined:
  - Opcodes 000100 and 000101 use mode 3 (`s << 2`).
- Not defined:
  - These opcodes decode as mode 0 (plain sign extend).
  - Mode 3 is never produced.
  - The shift logic is absent.

## Test plan
- Reset, then opcode 001000, imm 0xFFFE, `i_ready=1` -> one cycle later: `o_valid=1`, `o_data_immD=0xFFFFFFFE`, mode 0.
- Opcode 001101, imm 0x8001 -> `0x00008001`, mode 1. Opcode 001111, imm 0x1234 -> `0x12340000`, mode 2. Opcode 000000 with funct 100100, imm 0x8000 -> `0x00008000`.
- With the macro defined, opcode 000100, imm 0xFFFF -> `0xFFFFFFFC`, mode 3. Without the macro -> `0xFFFFFFFF`, mode 0.
- Stream 3 entries with `i_ready` held low after the first -> `o_ready` drops after the second entry is accepted; the first is held stable. Raise `i_ready` -> all 3 emerge in order, with no loss or duplication.
- FULL state plus `i_flush=1` with `i_valid=1` -> next cycle `o_valid=0` and `o_ready=1`. Nothing offered in that cycle appears later.
- Assert `i_rst` asynchronously mid-stream while in FULL -> `o_valid=0` and `o_data_immD=0` immediately, without waiting for a clock edge.
